fetch_queue: RTL and testbench
==============================

# fetch_queue

Prefetch buffer between instruction memory and decode. It captures (PC, instruction) pairs produced by the fetch stage and instruction memory. It presents them in order to decode over a valid/ready handshake, so fetch can keep running while decode stalls. A taken branch flushes every buffered entry.

## Interface
- `DEPTH`, 4, number of entries; power of two, ≥2.
- `N`, 64, PC width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `enq_valid_F` input 1: fetch offers an entry this cycle.
- `enq_pc_F` input N: PC of the offered instruction.
- `enq_instr_F` input 32: instruction word read from imem at `enq_pc_F`.
- `enq_ready_F` output 1: queue accepts an entry this cycle.
- `flush_F` input 1: taken branch (PCSrc); discards all entries.
- `deq_valid_D` output 1: head entry is presented to decode.
- `deq_pc_D` output N: PC of the head entry.
- `deq_instr_D` output 32: instruction of the head entry.
- `deq_ready_D` input 1: decode consumes the head this cycle.
- `count` output $clog2(DEPTH)+1: number of stored entries.
- `full` output 1: count == DEPTH.
- `empty` output 1: count == 0.

## Operation
- Storage: circular buffer of DEPTH (pc, instr) entries, with a read pointer and a write pointer of $clog2(DEPTH) bits. Pointers wrap modulo DEPTH.
- Enqueue fires when `enq_valid_F && enq_ready_F`. The entry is written at the write pointer, and the write pointer advances by 1.
- Dequeue fires when `deq_valid_D && deq_ready_D`. The read pointer advances by 1.
- `count` next value:
  - +1 on enqueue only.
  - −1 on dequeue only.
  - Unchanged when both fire or neither fires.
- `enq_ready_F` = !full && !flush_F.
  - When full, enqueue is refused even if a dequeue fires in the same cycle.
- `deq_valid_D` = !empty && !flush_F (plus the bypass case under Configuration).
- `deq_pc_D` and `deq_instr_D` equal the head entry when `deq_valid_D` is 1, and are driven 0 otherwise.
- Flush (`flush_F` = 1):
  - Same cycle: no enqueue or dequeue fires, because both handshakes are forced low.
  - Next edge: pointers and `count` are cleared to 0.
  - Stale storage contents remain but are never presented.
- Order is strictly FIFO. There is no reordering and no duplicate delivery.
- Reset (asynchronous, active-low, legal at any time including mid-transfer):
  - Pointers, `count` and all storage are set to 0.
  - While reset is low, outputs are: `deq_valid_D`=0, `deq_pc_D`=0, `deq_instr_D`=0, `count`=0, `empty`=1, `full`=0, `enq_ready_F`=1 (subject to `flush_F`).
  - Entries in flight are lost.

## Timing
- Base latency: an entry enqueued at edge k is visible on `deq_*_D` in cycle k+1 and may be dequeued in that cycle.
- Sustained throughput: 1 entry per cycle when decode is always ready. `count` then stays constant.
- `enq_ready_F`, `deq_valid_D`, `full`, `empty` and `count` are combinational from registered state, except for the `flush_F` gating and the bypass path.
- `deq_ready_D` has no combinational path to `enq_ready_F`.
- Flush takes effect on the edge after it is asserted. `flush_F` held for multiple cycles keeps the queue empty and both handshakes low.
- Reset is asynchronous. Release is sampled on `clk`, and the first enqueue is possible at the first edge after `reset` goes high.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined:
  - When `empty`, `enq_valid_F`=1 and `flush_F`=0, the offered entry is driven combinationally onto `deq_*_D` with `deq_valid_D`=1.
  - If `deq_ready_D`=1, the entry passes through without being stored, and `count` stays 0 (zero latency).
  - If `deq_ready_D`=0, the entry is stored normally.
- `FETCH_QUEUE_BYPASS_EN` not defined:
  - No bypass path exists, and the minimum latency is 1 cycle as described under Timing.

## Test plan
- Reset then idle:
  - Pulse `reset` low mid-cycle → outputs take reset values immediately.
  - After release → `empty`=1, `enq_ready_F`=1, `deq_valid_D`=0.
- Fill and backpressure:
  - With `deq_ready_D`=0, offer PCs 0x0, 0x4, 0x8, 0xC, 0x10 → first four accepted.
  - Then `full`=1 and `enq_ready_F`=0, so 0x10 is held.
  - Raise `deq_ready_D` → 0x0, 0x4, 0x8, 0xC, 0x10 are dequeued in order.
- Streaming and wrap-around:
  - 20 back-to-back enqueues (PC 0x100 + 4i) with `deq_ready_D`=1 → all 20 dequeued in order; pointers wrap 5 times; no loss.
- Flush:
  - With 3 entries stored, assert `flush_F` for 1 cycle while `enq_valid_F`=1 → enqueue refused, `deq_valid_D`=0 that cycle.
  - Next cycle `count`=0.
  - A new PC 0x400 is then delivered as the next head.
- Bypass:
  - Empty queue, `enq_valid_F`=1 with PC 0x80, `deq_ready_D`=1.
  - With `FETCH_QUEUE_BYPASS_EN` → `deq_pc_D`=0x80 in the same cycle, and `count` stays 0.
  - Without the macro → 0x80 appears the next cycle.
- Reset mid-stream:
  - With 2 entries stored, assert `reset` → `count`=0 and `deq_valid_D`=0 immediately.
  - After release, the first new enqueue appears as head.

Source files
------------

// File: rtl/fetch_queue.sv
// Prefetch FIFO between instruction fetch and decode; a taken branch (flush_F) empties it.
// Optional zero-latency pass-through when empty is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned N     = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enq_valid_F,
    input  logic [N-1:0]             enq_pc_F,
    input  logic [31:0]              enq_instr_F,
    output logic                     enq_ready_F,
    input  logic                     flush_F,
    output logic                     deq_valid_D,
    output logic [N-1:0]             deq_pc_D,
    output logic [31:0]              deq_instr_D,
    input  logic                     deq_ready_D,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [PtrW:0] FullCount = (PtrW + 1)'(DEPTH);

    logic [N-1:0]    pc_q    [DEPTH];
    logic [31:0]     instr_q [DEPTH];
    logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
    logic [PtrW:0]   count_q, count_d;

    logic bypass, pass_through, enq_fire, deq_fire, push, pop, head_valid;

    assign full        = (count_q == FullCount);
    assign empty       = (count_q == '0);
    assign count       = count_q;
    assign enq_ready_F = !full && !flush_F;
    assign head_valid  = !empty && !flush_F;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty && enq_valid_F && !flush_F;
`else
    assign bypass = 1'b0;
`endif

    assign deq_valid_D  = head_valid || bypass;
    assign enq_fire     = enq_valid_F && enq_ready_F;
    assign deq_fire     = deq_valid_D && deq_ready_D;
    // A bypassed entry consumed in the same cycle never touches storage.
    assign pass_through = bypass && deq_ready_D;
    assign push         = enq_fire && !pass_through;
    assign pop          = deq_fire && !pass_through;

    always_comb begin
        deq_pc_D    = '0;
        deq_instr_D = '0;
        if (head_valid) begin
            deq_pc_D    = pc_q[rd_ptr_q];
            deq_instr_D = instr_q[rd_ptr_q];
        end else if (bypass) begin
            deq_pc_D    = enq_pc_F;
            deq_instr_D = enq_instr_F;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + (PtrW + 1)'(1);
            2'b01:   count_d = count_q - (PtrW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_q[i]    <= '0;
                instr_q[i] <= '0;
            end
        end else if (flush_F) begin
            // Storage is left stale; cleared pointers keep it from being presented.
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                pc_q[wr_ptr_q]    <= enq_pc_F;
                instr_q[wr_ptr_q] <= enq_instr_F;
                wr_ptr_q          <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned N     = 64;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          enq_valid_F = 1'b0;
    logic [N-1:0]  enq_pc_F = '0;
    logic [31:0]   enq_instr_F = '0;
    logic          enq_ready_F;
    logic          flush_F = 1'b0;
    logic          deq_valid_D;
    logic [N-1:0]  deq_pc_D;
    logic [31:0]   deq_instr_D;
    logic          deq_ready_D = 1'b0;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [N-1:0] pc;
        logic [31:0]  instr;
    } entry_t;

    entry_t       mq[$];
    logic [N-1:0] got[$];

    fetch_queue #(.DEPTH(DEPTH), .N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .enq_valid_F (enq_valid_F),
        .enq_pc_F    (enq_pc_F),
        .enq_instr_F (enq_instr_F),
        .enq_ready_F (enq_ready_F),
        .flush_F     (flush_F),
        .deq_valid_D (deq_valid_D),
        .deq_pc_D    (deq_pc_D),
        .deq_instr_D (deq_instr_D),
        .deq_ready_D (deq_ready_D),
        .count       (count),
        .full        (full),
        .empty       (empty)
    );

    always #5 clk = ~clk;

    // Reference model: outputs derived from the model queue and current inputs.
    function automatic logic m_bypass();
`ifdef FETCH_QUEUE_BYPASS_EN
        return (mq.size() == 0) && enq_valid_F && !flush_F;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic m_enq_ready();
        return (mq.size() < int'(DEPTH)) && !flush_F;
    endfunction

    function automatic logic m_deq_valid();
        return ((mq.size() > 0) && !flush_F) || m_bypass();
    endfunction

    function automatic logic [N-1:0] m_pc();
        if ((mq.size() > 0) && !flush_F) return mq[0].pc;
        if (m_bypass()) return enq_pc_F;
        return '0;
    endfunction

    function automatic logic [31:0] m_instr();
        if ((mq.size() > 0) && !flush_F) return mq[0].instr;
        if (m_bypass()) return enq_instr_F;
        return '0;
    endfunction

    // Advance the model by one clock edge using the current inputs, then step the clock.
    task automatic tick(output logic enq_f, output logic deq_f);
        logic byp_pass;
        enq_f    = enq_valid_F && m_enq_ready();
        deq_f    = m_deq_valid() && deq_ready_D;
        byp_pass = m_bypass() && deq_ready_D;
        if (flush_F) mq.delete();
        else if (!byp_pass) begin
            if (deq_f) void'(mq.pop_front());
            if (enq_f) mq.push_back('{pc: enq_pc_F, instr: enq_instr_F});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        logic ef, df;
        tick(ef, df);
    endtask

    task automatic drain();
        enq_valid_F = 1'b0;
        flush_F     = 1'b0;
        deq_ready_D = 1'b1;
        for (int i = 0; i < int'(DEPTH) + 2; i++) step();
        deq_ready_D = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (enq_ready_F !== 1'b1) begin errors++; $display("FAIL reset_enq_ready got %b exp 1", enq_ready_F); end
        checks++; if (deq_valid_D !== 1'b0) begin errors++; $display("FAIL reset_deq_valid got %b exp 0", deq_valid_D); end
        checks++; if (deq_pc_D !== '0) begin errors++; $display("FAIL reset_deq_pc got %h exp 0", deq_pc_D); end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        step();
        @(negedge clk);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL idle_empty got %b exp 1", empty); end
        checks++; if (enq_ready_F !== 1'b1) begin errors++; $display("FAIL idle_enq_ready got %b exp 1", enq_ready_F); end
        checks++; if (deq_valid_D !== 1'b0) begin errors++; $display("FAIL idle_deq_valid got %b exp 0", deq_valid_D); end
        step();
    endtask

    task automatic test_fill_backpressure();
        logic ef, df;
        int   cyc;
        deq_ready_D = 1'b0;
        for (int i = 0; i < 5; i++) begin
            enq_valid_F = 1'b1;
            enq_pc_F    = N'(4 * i);
            enq_instr_F = $urandom;
            @(negedge clk);
            checks++;
            if (enq_ready_F !== (i < 4)) begin
                errors++; $display("FAIL fill_enq_ready[%0d] got %b exp %b", i, enq_ready_F, (i < 4));
            end
            if (i == 4) begin
                checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", full); end
                checks++; if (count !== CW'(4)) begin errors++; $display("FAIL fill_count got %0d exp 4", count); end
            end
            tick(ef, df);
        end
        // 0x10 stays offered until space frees up.
        deq_ready_D = 1'b1;
        got.delete();
        cyc = 0;
        while ((enq_valid_F || mq.size() > 0) && cyc < 20) begin
            @(negedge clk);
            checks++;
            if (deq_pc_D !== m_pc() || deq_instr_D !== m_instr()) begin
                errors++; $display("FAIL drain_head got %h/%h exp %h/%h", deq_pc_D, deq_instr_D, m_pc(), m_instr());
            end
            if (deq_valid_D) got.push_back(deq_pc_D);
            tick(ef, df);
            if (ef) enq_valid_F = 1'b0;
            cyc++;
        end
        checks++;
        if (got.size() != 5) begin
            errors++; $display("FAIL drain_len got %0d exp 5", got.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                checks++;
                if (got[k] !== N'(4 * k)) begin
                    errors++; $display("FAIL drain_order[%0d] got %h exp %h", k, got[k], N'(4 * k));
                end
            end
        end
        deq_ready_D = 1'b0;
    endtask

    task automatic test_streaming();
        logic ef, df;
        int   sent;
        int   cyc;
        deq_ready_D = 1'b1;
        got.delete();
        sent = 0;
        cyc  = 0;
        while ((sent < 20 || mq.size() > 0) && cyc < 60) begin
            enq_valid_F = (sent < 20);
            enq_pc_F    = N'(32'h100 + 4 * sent);
            enq_instr_F = $urandom;
            @(negedge clk);
            checks++;
            if (deq_valid_D !== m_deq_valid() || deq_pc_D !== m_pc() || count !== CW'(mq.size())) begin
                errors++;
                $display("FAIL stream_out got v%b pc%h c%0d exp v%b pc%h c%0d", deq_valid_D, deq_pc_D,
                         count, m_deq_valid(), m_pc(), mq.size());
            end
            if (deq_valid_D) got.push_back(deq_pc_D);
            tick(ef, df);
            if (ef) sent++;
            cyc++;
        end
        enq_valid_F = 1'b0;
        checks++;
        if (got.size() != 20) begin
            errors++; $display("FAIL stream_len got %0d exp 20", got.size());
        end else begin
            for (int k = 0; k < 20; k++) begin
                checks++;
                if (got[k] !== N'(32'h100 + 4 * k)) begin
                    errors++; $display("FAIL stream_order[%0d] got %h exp %h", k, got[k], N'(32'h100 + 4 * k));
                end
            end
        end
        deq_ready_D = 1'b0;
    endtask

    task automatic test_flush();
        logic [31:0] instr;
        deq_ready_D = 1'b0;
        for (int i = 0; i < 3; i++) begin
            enq_valid_F = 1'b1;
            enq_pc_F    = N'(32'h200 + 4 * i);
            enq_instr_F = $urandom;
            step();
        end
        flush_F  = 1'b1;
        enq_pc_F = N'(32'h999);
        @(negedge clk);
        checks++; if (enq_ready_F !== 1'b0) begin errors++; $display("FAIL flush_enq_ready got %b exp 0", enq_ready_F); end
        checks++; if (deq_valid_D !== 1'b0) begin errors++; $display("FAIL flush_deq_valid got %b exp 0", deq_valid_D); end
        checks++; if (count !== CW'(3)) begin errors++; $display("FAIL flush_count_before got %0d exp 3", count); end
        step();
        flush_F     = 1'b0;
        enq_valid_F = 1'b0;
        @(negedge clk);
        checks++; if (count !== '0) begin errors++; $display("FAIL flush_count_after got %0d exp 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL flush_empty got %b exp 1", empty); end
        step();
        instr       = $urandom;
        enq_valid_F = 1'b1;
        enq_pc_F    = N'(32'h400);
        enq_instr_F = instr;
        step();
        enq_valid_F = 1'b0;
        @(negedge clk);
        checks++;
        if (deq_valid_D !== 1'b1 || deq_pc_D !== N'(32'h400) || deq_instr_D !== instr) begin
            errors++; $display("FAIL flush_new_head got v%b %h/%h exp v1 400/%h", deq_valid_D, deq_pc_D, deq_instr_D, instr);
        end
        drain();
    endtask

    task automatic test_bypass();
        deq_ready_D = 1'b1;
        enq_valid_F = 1'b1;
        enq_pc_F    = N'(32'h80);
        enq_instr_F = $urandom;
        @(negedge clk);
        checks++;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (deq_valid_D !== 1'b1 || deq_pc_D !== N'(32'h80)) begin
            errors++; $display("FAIL bypass_same_cycle got v%b %h exp v1 80", deq_valid_D, deq_pc_D);
        end
`else
        if (deq_valid_D !== 1'b0) begin
            errors++; $display("FAIL bypass_same_cycle got v%b exp v0", deq_valid_D);
        end
`endif
        step();
        enq_valid_F = 1'b0;
        @(negedge clk);
        checks++;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (count !== '0 || deq_valid_D !== 1'b0) begin
            errors++; $display("FAIL bypass_next got c%0d v%b exp c0 v0", count, deq_valid_D);
        end
`else
        if (deq_valid_D !== 1'b1 || deq_pc_D !== N'(32'h80)) begin
            errors++; $display("FAIL bypass_next got v%b %h exp v1 80", deq_valid_D, deq_pc_D);
        end
`endif
        step();
        deq_ready_D = 1'b0;
    endtask

    task automatic test_reset_midstream();
        logic [N-1:0] pc;
        logic [31:0]  instr;
        deq_ready_D = 1'b0;
        for (int i = 0; i < 2; i++) begin
            enq_valid_F = 1'b1;
            enq_pc_F    = {$urandom, $urandom};
            enq_instr_F = $urandom;
            step();
        end
        enq_valid_F = 1'b0;
        @(negedge clk);
        checks++; if (count !== CW'(2)) begin errors++; $display("FAIL mid_count_before got %0d exp 2", count); end
        #2;
        reset = 1'b0;
        #1;
        mq.delete();
        checks++; if (count !== '0) begin errors++; $display("FAIL mid_count got %0d exp 0", count); end
        checks++; if (deq_valid_D !== 1'b0) begin errors++; $display("FAIL mid_deq_valid got %b exp 0", deq_valid_D); end
        checks++; if (empty !== 1'b1 || deq_pc_D !== '0) begin
            errors++; $display("FAIL mid_empty_pc got e%b %h exp e1 0", empty, deq_pc_D);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        pc          = {$urandom, $urandom};
        instr       = $urandom;
        enq_valid_F = 1'b1;
        enq_pc_F    = pc;
        enq_instr_F = instr;
        step();
        enq_valid_F = 1'b0;
        @(negedge clk);
        checks++;
        if (deq_valid_D !== 1'b1 || deq_pc_D !== pc || deq_instr_D !== instr || count !== CW'(1)) begin
            errors++; $display("FAIL mid_new_head got v%b %h/%h c%0d exp v1 %h/%h c1", deq_valid_D, deq_pc_D,
                               deq_instr_D, count, pc, instr);
        end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            enq_valid_F = ($urandom_range(0, 3) != 0);
            deq_ready_D = ($urandom_range(0, 2) != 0);
            flush_F     = ($urandom_range(0, 19) == 0);
            enq_pc_F    = {$urandom, $urandom};
            enq_instr_F = $urandom;
            @(negedge clk);
            checks++; if (count !== CW'(mq.size())) begin errors++; $display("FAIL rand_count got %0d exp %0d", count, mq.size()); end
            checks++; if (full !== (mq.size() == int'(DEPTH))) begin errors++; $display("FAIL rand_full got %b", full); end
            checks++; if (empty !== (mq.size() == 0)) begin errors++; $display("FAIL rand_empty got %b", empty); end
            checks++; if (enq_ready_F !== m_enq_ready()) begin errors++; $display("FAIL rand_enq_ready got %b exp %b", enq_ready_F, m_enq_ready()); end
            checks++; if (deq_valid_D !== m_deq_valid()) begin errors++; $display("FAIL rand_deq_valid got %b exp %b", deq_valid_D, m_deq_valid()); end
            checks++; if (deq_pc_D !== m_pc()) begin errors++; $display("FAIL rand_deq_pc got %h exp %h", deq_pc_D, m_pc()); end
            checks++; if (deq_instr_D !== m_instr()) begin errors++; $display("FAIL rand_deq_instr got %h exp %h", deq_instr_D, m_instr()); end
            step();
        end
        flush_F = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_fill_backpressure();
        test_streaming();
        test_flush();
        test_bypass();
        test_reset_midstream();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
